shift_register_piso: RTL and testbench



---
 rtl/shift_register_pkg.sv | 17 +
 rtl/shift_register_tick.sv | 42 ++++
 rtl/shift_register_piso.sv | 110 +++++++++++
 tb/tb_shift_register_piso.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// shift_register_pkg
// Shared definitions for the shift_register_* family (PISO, SIPO, tick).
//   state_e   : two-state control FSM encoding (IDLE, SHIFT)
//   cnt_width : counter width for a count of n values, never below 1 bit
package shift_register_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // $clog2(1) is 0, which cannot size a vector; clamp to one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_register_tick.sv
// shift_register_tick
// Bit-period divider: emits a one-cycle tick every CLKS_PER_BIT enabled
// cycles. With CLKS_PER_BIT=1 the counter is pinned at 0 and tick == enable.
// Ports:
//   clk_i   in  system clock
//   rst_ni  in  asynchronous active-low reset
//   clear_i in  restart the period (takes priority over enable)
//   en_i    in  count this cycle
//   tick_o  out enabled cycle in which the counter sits at CLKS_PER_BIT-1
import shift_register_pkg::*;

module shift_register_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned   CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick_o = en_i & w_at_last;

endmodule

// File: rtl/shift_register_piso.sv
// shift_register_piso
// Parallel-in serial-out shift register with a valid/ready input handshake.
// An accepted WIDTH-bit word is emitted MSB-first on bit_o, one bit per
// CLKS_PER_BIT cycles, with advance_o strobing the cycle the downstream
// stage (shift_register_sipo) should sample bit_o.
// Optional feature: define SHIFT_REGISTER_PISO_BACK_TO_BACK_EN to allow a new
// word to be accepted in the done_o cycle, removing the one-cycle IDLE gap.
// Ports:
//   clk_i     in  system clock
//   rst_ni    in  asynchronous active-low reset
//   data_i    in  [WIDTH] word to serialize, sampled on accept
//   valid_i   in  data_i is valid
//   ready_o   out block can accept a word this cycle
//   bit_o     out current serial bit, MSB first (0 when idle)
//   advance_o out one-cycle strobe: downstream samples bit_o
//   busy_o    out a word is being shifted out
//   done_o    out one-cycle pulse on the final advance of a word
import shift_register_pkg::*;

module shift_register_piso #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             advance_o,
  output logic             busy_o,
  output logic             done_o
);

`ifdef SHIFT_REGISTER_PISO_BACK_TO_BACK_EN
  localparam bit BACK_TO_BACK = 1'b1;
`else
  localparam bit BACK_TO_BACK = 1'b0;
`endif

  localparam int unsigned   BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;

  logic w_busy;
  logic w_tick;
  logic w_last;
  logic w_ready;
  logic w_accept;

  assign w_busy = (r_state == SHIFT);
  assign w_last = w_tick && (r_bitcnt == LAST_BIT);

  // ready depends only on registered state (w_last is decoded from the
  // state and counters), so valid_i never reaches an output combinationally.
  assign w_ready  = !w_busy || (BACK_TO_BACK && w_last);
  assign w_accept = valid_i && w_ready;

  shift_register_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(w_accept),
    .en_i   (w_busy),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = SHIFT;
      SHIFT: if (w_last)   w_state_nxt = w_accept ? SHIFT : IDLE;
    endcase
  end

  // An accept in the final advance cycle (back-to-back) wins over the shift,
  // so the new word's MSB is on bit_o the very next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else if (w_accept) begin
      r_shreg  <= data_i;
      r_bitcnt <= '0;
    end else if (w_tick) begin
      r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
      r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
    end
  end

  assign ready_o   = w_ready;
  assign busy_o    = w_busy;
  assign bit_o     = w_busy & r_shreg[WIDTH-1];
  assign advance_o = w_tick;
  assign done_o    = w_last;

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso: two instances (CLKS_PER_BIT 1 and 3) driven
// by directed and random words, checked against a per-cycle model derived
// from the timing rules, plus a SIPO-style reassembly of the sampled bits.
module tb_shift_register_piso;

  localparam int W = 8;

`ifdef SHIFT_REGISTER_PISO_BACK_TO_BACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0][W-1:0] data;
  logic [1:0]        valid;
  logic [1:0]        ready, bitv, adv, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_register_piso #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .bit_o(bitv[0]), .advance_o(adv[0]),
    .busy_o(busy[0]), .done_o(done[0])
  );

  shift_register_piso #(.WIDTH(W), .CLKS_PER_BIT(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .bit_o(bitv[1]), .advance_o(adv[1]),
    .busy_o(busy[1]), .done_o(done[1])
  );

  function automatic int cpb(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // {busy, bit, advance, done, ready}
  function automatic logic [4:0] outs(input int d);
    return {busy[d], bitv[d], adv[d], done[d], ready[d]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string tag);
    chk($sformatf("%s_d%0d_idle", tag, d), {27'd0, outs(d)}, 32'b00001);
  endtask

  // Present a word and wait (bounded) for the accept edge; returns in the
  // first cycle after acceptance. valid stays high; caller drops it.
  task automatic accept(input int d, input logic [W-1:0] w);
    int n = 0;
    data[d]  = w;
    valid[d] = 1'b1;
    while (ready[d] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk($sformatf("d%0d_ready_timeout", d), 32'd0, 32'd1);
    step();
  endtask

  // Check ncyc cycles of a word starting at cycle N+1 after its accept.
  // A full word also checks the reassembled value seen by a chained SIPO.
  task automatic monitor(input int d, input logic [W-1:0] w, input int ncyc);
    int            c_per = cpb(d);
    int            total = W * c_per;
    logic [W-1:0]  sipo  = '0;
    logic [4:0]    exp;
    int            idx;
    for (int c = 1; c <= ncyc; c++) begin
      idx = W - 1 - (c - 1) / c_per;
      exp = {1'b1, w[idx], (c % c_per) == 0, c == total, BTB && (c == total)};
      chk($sformatf("d%0d_w%02h_c%0d", d, w, c), {27'd0, outs(d)}, {27'd0, exp});
      if (adv[d] === 1'b1) sipo = {sipo[W-2:0], bitv[d]};
      step();
    end
    if (ncyc == total) chk($sformatf("d%0d_sipo_%02h", d, w), {24'd0, sipo}, {24'd0, w});
  endtask

  task automatic run_word(input int d, input logic [W-1:0] w);
    accept(d, w);
    valid[d] = 1'b0;
    data[d]  = ~w;
    monitor(d, w, W * cpb(d));
    check_idle(d, $sformatf("post_%02h", w));
  endtask

  initial begin
    logic [W-1:0] rw;
    int           d, gap;

    // Reset with valid asserted: everything held idle.
    rst_n = 1'b0;
    valid = 2'b11;
    data  = {8'h55, 8'hAA};
    repeat (3) step();
    check_idle(0, "rst");
    check_idle(1, "rst");
    valid = 2'b00;
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check_idle(0, "after_rst");
      check_idle(1, "after_rst");
    end

    // Single word, one clock per bit; paced word, three clocks per bit.
    run_word(0, 8'hA5);
    run_word(1, 8'h3C);

    // Busy hold-off: 0xFF presented throughout a 0x01 transfer.
    accept(0, 8'h01);
    data[0] = 8'hFF;
    monitor(0, 8'h01, W);
    if (!BTB) begin
      check_idle(0, "holdoff_gap");
      step();
    end
    valid[0] = 1'b0;
    monitor(0, 8'hFF, W);
    check_idle(0, "holdoff_end");

    // Reset after three advances of 0xA5 on the paced instance.
    accept(1, 8'hA5);
    valid[1] = 1'b0;
    monitor(1, 8'hA5, 9);
    rst_n = 1'b0;
    #1;
    check_idle(1, "midword_rst");
    step();
    check_idle(1, "midword_rst_hold");
    rst_n = 1'b1;
    step();
    check_idle(1, "midword_rst_rel");
    run_word(1, 8'h5A);

    // Random words with random idle gaps on both instances.
    for (int i = 0; i < 8; i++) begin
      d   = i % 2;
      rw  = W'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        step();
        check_idle(d, "gap");
      end
      run_word(d, rw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
